// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback
// steps, flags unsupported opcodes and counts retired instructions.
`timescale 1ns/1ps

module multicycle_control #(
  // Retire counter reset value; a nonzero value lets the wrap be reached without 64k retires.
  parameter logic [15:0] CountRstVal = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        imem_ready_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [3:0]  state_o,
  output logic        illegal_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  logic        retire;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      count_q   <= CountRstVal;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SrcBReg;
    alu_op_o     = AluAdd;

    // Reset forces every output low combinationally, not just after the next edge.
    if (!reset_i) begin
      case (state_q)
        StFetch: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SrcBFour;
          ir_write_o  = imem_ready_i;
          pc_write_o  = imem_ready_i;
          if (imem_ready_i) state_d = StDecode;
        end
        StDecode: begin
          alu_src_b_o = SrcBImm;
          case (opcode_i)
            OpLoad, OpStore: state_d = StMemAdr;
            OpRtype:         state_d = StExec;
            OpBranch:        state_d = StBranch;
            default: begin
              state_d   = StHalt;
              illegal_d = 1'b1;
            end
          endcase
        end
        StMemAdr: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SrcBImm;
          state_d     = (opcode_i == OpLoad) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
          if (dmem_ready_i) state_d = StMemWb;
        end
        StMemWb: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          retire       = 1'b1;
          state_d      = StFetch;
        end
        StMemWr: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
          if (dmem_ready_i) begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
        StExec: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = AluFunct;
          state_d     = StAluWb;
        end
        StAluWb: begin
          reg_write_o = 1'b1;
          retire      = 1'b1;
          state_d     = StFetch;
        end
        StBranch: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = AluSub;
          pc_write_o  = zero_i;
          retire      = 1'b1;
          state_d     = StFetch;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end

    count_d = retire ? count_q + 16'd1 : count_q;
  end

  assign state_o       = state_q;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 opcode  input  7  opcode field of the instruction register, bits [6:0].
REQ-004 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-005 imem_ready  input  1  instruction memory has valid data this cycle.
REQ-006 dmem_ready  input  1  data memory access completes this cycle.
REQ-007 pc_write  output  1  PC load enable.
REQ-008 ir_write  output  1  instruction register load enable.
REQ-009 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 mem_read, mem_write  output  1 each  data/instruction memory strobes.
REQ-011 reg_write  output  1  register file write enable.
REQ-012 mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR.
REQ-013 alu_src_a  output  1  0=PC, 1=regA.
REQ-014 alu_src_b  output  2  00=regB, 01=constant 4, 10=immediate.
REQ-015 alu_op  output  2  00=add, 01=subtract, 10=decode funct fields; drives the ALU control decoder.
REQ-016 state  output  4  current state encoding, for debug.
REQ-017 illegal  output  1  sticky flag: unsupported opcode decoded.
REQ-018 instr_count  output  16  count of retired instructions.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, HALT=9.
REQ-020 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=imem_ready; advance to DECODE only when imem_ready=1, else hold.
REQ-021 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute); next state by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXEC, 1100011 -> BRANCH, any other -> HALT with illegal set.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode=0000011, else MEMWR.
REQ-023 MEMRD: mem_read=1, iord=1; hold until dmem_ready=1, then MEMWB.
REQ-024 MEMWB: reg_write=1, mem_to_reg=1; next FETCH; retires.
REQ-025 MEMWR: mem_write=1, iord=1; hold until dmem_ready=1, then FETCH; retires on the dmem_ready cycle.
REQ-026 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB.
REQ-027 ALUWB: reg_write=1, mem_to_reg=0; next FETCH; retires.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write=zero; next FETCH; retires regardless of zero.
REQ-029 HALT: all enables 0; remains until reset.
REQ-030 Outputs not listed for a state SHALL be 0.
REQ-031 instr_count SHALL increment by 1 on each retire cycle and wrap 16'hFFFF -> 16'h0000.
REQ-032 A waiting state (FETCH, MEMRD, MEMWR) SHALL hold its strobes asserted for every stall cycle; no retire while stalled.
REQ-033 Latency: R-type 4 cycles, beq 3, ld 5, sd 4, each at zero wait states.

Reset
REQ-034 On reset assertion, state=FETCH, illegal=0, instr_count=0 immediately, regardless of clock or current state (including mid-MEMWR).
REQ-035 While reset is high, all enables (pc_write, ir_write, mem_read, mem_write, reg_write) SHALL be 0; first FETCH activity on the first rising edge after deassertion.

Verification
REQ-036 R-type 0110011, imem_ready=1: states 0,1,6,7,0; reg_write=1 only in ALUWB; alu_op=10 in EXEC; instr_count 0 -> 1.
REQ-037 ld 0000011, dmem_ready low 2 cycles in MEMRD: mem_read held 3 cycles; total 7 cycles; mem_to_reg=1 in MEMWB.
REQ-038 beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both retire, count +1 each.
REQ-039 Opcode 1111111 -> HALT, illegal=1, enables 0 for 10 cycles; reset clears to FETCH, illegal=0.
REQ-040 Preload instr_count near 16'hFFFF via 65535 retires, one more retire -> 16'h0000.
REQ-041 Reset asserted mid-MEMWR between clock edges -> mem_write drops to 0 and state=0 before the next edge.
